// File: rtl/dsp_ema_averager_if.sv
// dsp_ema_averager_if: sample-in / average-out bus of the multi-channel EMA averager
interface dsp_ema_averager_if #(
    parameter int DATA_W  = 12,
    parameter int CH_W    = 2,
    parameter int SHIFT_W = 3
);
    logic               i_valid;
    logic               i_sop;
    logic               i_ovf;
    logic [CH_W-1:0]    i_chan;
    logic [DATA_W-1:0]  i_data;
    logic [SHIFT_W-1:0] i_shift;
    logic               o_valid;
    logic               o_sop;
    logic [CH_W-1:0]    o_chan;
    logic [DATA_W-1:0]  o_data;

    modport master (
        output i_valid, i_sop, i_ovf, i_chan, i_data, i_shift,
        input  o_valid, o_sop, o_chan, o_data
    );

    modport slave (
        input  i_valid, i_sop, i_ovf, i_chan, i_data, i_shift,
        output o_valid, o_sop, o_chan, o_data
    );
endinterface

// File: rtl/dsp_ema_averager.sv
// dsp_ema_averager: multi-channel EMA (weight 2^-k) over framed packets; DSP_AVG_ROUND_EN selects rounded output
module dsp_ema_averager #(
    parameter int DATA_W   = 12,
    parameter int CHANNELS = 4,
    parameter int FRAC_W   = 4,
    parameter int SHIFT_W  = 3
) (
    input logic i_clk,
    input logic i_rst,
    dsp_ema_averager_if.slave bus
);
    localparam int CH_W = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
    localparam int NCH  = 1 << CH_W;
    localparam int AW   = DATA_W + FRAC_W;

    typedef enum logic [1:0] {IDLE, RUN, DROP} st_t;

    logic               v1_q, v1_d, sop1_q, sop1_d, ovf1_q, ovf1_d;
    logic [CH_W-1:0]    chan1_q, chan1_d;
    logic [DATA_W-1:0]  data1_q, data1_d;
    logic [SHIFT_W-1:0] shift1_q, shift1_d;
    logic [AW-1:0]      acc_q [NCH];
    logic [AW-1:0]      acc_d [NCH];
    logic [SHIFT_W-1:0] k_q [NCH];
    logic [SHIFT_W-1:0] k_d [NCH];
    st_t                st_q [NCH];
    st_t                st_d [NCH];
    logic               ov_q, ov_d, osop_q, osop_d;
    logic [CH_W-1:0]    ochan_q, ochan_d;
    logic [DATA_W-1:0]  odata_q, odata_d;
    logic [AW-1:0]      acc_cur, x, acc_new;
    logic signed [AW:0] diff, delta;
    logic [SHIFT_W-1:0] k_use;
    st_t                st_cur;
    logic               live, emit;
`ifdef DSP_AVG_ROUND_EN
    localparam logic [AW:0] HALF = FRAC_W > 0 ? (AW+1)'(1) << (FRAC_W > 0 ? FRAC_W - 1 : 0) : '0;
    logic [AW:0] rnd;
`endif

    // Stage-2 datapath: state written at the edge is what the next sample reads, so back-to-back needs no forwarding
    always_comb begin
        v1_d     = bus.i_valid;
        sop1_d   = bus.i_sop;
        ovf1_d   = bus.i_ovf;
        chan1_d  = bus.i_chan;
        data1_d  = bus.i_data;
        shift1_d = bus.i_shift;
        acc_cur  = acc_q[chan1_q];
        st_cur   = st_q[chan1_q];
        k_use    = sop1_q ? shift1_q : k_q[chan1_q];
        x        = AW'(data1_q) << FRAC_W;
        diff     = $signed({1'b0, x}) - $signed({1'b0, acc_cur});
        delta    = diff >>> k_use;
        acc_new  = sop1_q ? x : acc_cur + AW'(delta);
        live     = v1_q && (sop1_q || st_cur == RUN);
        emit     = live && !ovf1_q;
        acc_d    = acc_q;
        k_d      = k_q;
        st_d     = st_q;
        if (live) st_d[chan1_q] = ovf1_q ? DROP : RUN;
        if (emit) acc_d[chan1_q] = acc_new;
        if (emit && sop1_q) k_d[chan1_q] = shift1_q;
        ov_d     = emit;
        osop_d   = emit ? sop1_q : osop_q;
        ochan_d  = emit ? chan1_q : ochan_q;
`ifdef DSP_AVG_ROUND_EN
        rnd      = ({1'b0, acc_new} + HALF) >> FRAC_W;
        odata_d  = emit ? (|rnd[AW:DATA_W] ? '1 : rnd[DATA_W-1:0]) : odata_q;
`else
        odata_d  = emit ? acc_new[AW-1:FRAC_W] : odata_q;
`endif
    end

    // Input register stage, per-channel state and registered outputs; reset drops everything in flight
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            v1_q     <= 1'b0;
            sop1_q   <= 1'b0;
            ovf1_q   <= 1'b0;
            chan1_q  <= '0;
            data1_q  <= '0;
            shift1_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                acc_q[i] <= '0;
                k_q[i]   <= '0;
                st_q[i]  <= IDLE;
            end
            ov_q     <= 1'b0;
            osop_q   <= 1'b0;
            ochan_q  <= '0;
            odata_q  <= '0;
        end else begin
            v1_q     <= v1_d;
            sop1_q   <= sop1_d;
            ovf1_q   <= ovf1_d;
            chan1_q  <= chan1_d;
            data1_q  <= data1_d;
            shift1_q <= shift1_d;
            acc_q    <= acc_d;
            k_q      <= k_d;
            st_q     <= st_d;
            ov_q     <= ov_d;
            osop_q   <= osop_d;
            ochan_q  <= ochan_d;
            odata_q  <= odata_d;
        end
    end

    assign bus.o_valid = ov_q;
    assign bus.o_sop   = osop_q;
    assign bus.o_chan  = ochan_q;
    assign bus.o_data  = odata_q;
endmodule

// File: tb/tb_dsp_ema_averager.sv
// tb_dsp_ema_averager: vector table, corner sequences and randomized traffic against an arithmetic reference model
module tb_dsp_ema_averager;
    localparam int DATA_W = 12, CHANNELS = 4, FRAC_W = 4, SHIFT_W = 3, CH_W = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dsp_ema_averager_if #(.DATA_W(DATA_W), .CH_W(CH_W), .SHIFT_W(SHIFT_W)) bus ();
    dsp_ema_averager_if #(.DATA_W(DATA_W), .CH_W(1), .SHIFT_W(SHIFT_W)) lb ();

    dsp_ema_averager #(.DATA_W(DATA_W), .CHANNELS(CHANNELS), .FRAC_W(FRAC_W), .SHIFT_W(SHIFT_W))
        dut (.i_clk(clk), .i_rst(rst), .bus(bus));
    dsp_ema_averager #(.DATA_W(DATA_W), .CHANNELS(1), .FRAC_W(0), .SHIFT_W(SHIFT_W))
        ldut (.i_clk(clk), .i_rst(rst), .bus(lb));

    typedef struct {
        bit v, sop, ovf;
        int ch, data, shift;
        bit ev, esop;
        int ech, edata;
    } vec_t;

    int total = 0, bad = 0;
    int m_acc [CHANNELS], m_k [CHANNELS], m_st [CHANNELS];
    bit p_ev, p_esop;
    int p_ech, p_edata;
    vec_t tbl [$];

    task automatic chk(input string n, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(bit v, bit sop, bit ovf, int ch, int data, int shift,
                                bit ev, bit esop, int ech, int edata);
        vec_t t;
        t.v = v; t.sop = sop; t.ovf = ovf; t.ch = ch; t.data = data; t.shift = shift;
        t.ev = ev; t.esop = esop; t.ech = ech; t.edata = edata;
        return t;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < CHANNELS; i++) begin
            m_acc[i] = 0; m_k[i] = 0; m_st[i] = 0;
        end
    endfunction

    function automatic int scale_out(int a);
        int r;
`ifdef DSP_AVG_ROUND_EN
        r = (a + (1 << (FRAC_W - 1))) / (1 << FRAC_W);
        if (r > (1 << DATA_W) - 1) r = (1 << DATA_W) - 1;
`else
        r = a / (1 << FRAC_W);
`endif
        return r;
    endfunction

    // States: 0 idle, 1 running, 2 dropping. acc holds the average scaled by 2^FRAC_W.
    function automatic void model(input vec_t t, output bit ev, output bit esop, output int ech, output int edata);
        int p, d, q;
        ev = 0; esop = t.sop; ech = t.ch; edata = 0;
        if (!t.v) return;
        if (t.sop) begin
            if (t.ovf) m_st[t.ch] = 2;
            else begin
                m_st[t.ch] = 1; m_k[t.ch] = t.shift; m_acc[t.ch] = t.data * (1 << FRAC_W); ev = 1;
            end
        end else if (m_st[t.ch] == 1) begin
            if (t.ovf) m_st[t.ch] = 2;
            else begin
                p = 1 << m_k[t.ch];
                d = t.data * (1 << FRAC_W) - m_acc[t.ch];
                q = d / p;
                if (d < 0 && q * p != d) q = q - 1;
                m_acc[t.ch] = m_acc[t.ch] + q;
                ev = 1;
            end
        end
        if (ev) edata = scale_out(m_acc[t.ch]);
    endfunction

    task automatic step(input vec_t t, input bit use_model);
        bit ev, esop;
        int ech, edata;
        bus.i_valid = t.v; bus.i_sop = t.sop; bus.i_ovf = t.ovf;
        bus.i_chan = CH_W'(t.ch); bus.i_data = DATA_W'(t.data); bus.i_shift = SHIFT_W'(t.shift);
        model(t, ev, esop, ech, edata);
        if (!use_model) begin
            ev = t.ev; esop = t.esop; ech = t.ech; edata = t.edata;
        end
        @(posedge clk);
        @(negedge clk);
        chk("o_valid", int'(bus.o_valid), int'(p_ev));
        if (p_ev) begin
            chk("o_sop", int'(bus.o_sop), int'(p_esop));
            chk("o_chan", int'(bus.o_chan), p_ech);
            chk("o_data", int'(bus.o_data), p_edata);
        end
        p_ev = ev; p_esop = esop; p_ech = ech; p_edata = edata;
    endtask

    initial begin
        vec_t t;
        int ld [5] = '{100, 200, 50, 0, 0};
        bit lv [5] = '{1, 1, 1, 0, 0};
        bit lev [5] = '{0, 1, 1, 1, 0};
        bit lsp [5] = '{0, 1, 0, 0, 0};
        int led [5] = '{0, 100, 150, 100, 0};

        rst = 1'b0;
        bus.i_valid = 0; bus.i_sop = 0; bus.i_ovf = 0; bus.i_chan = 0; bus.i_data = 0; bus.i_shift = 0;
        lb.i_valid = 0; lb.i_sop = 0; lb.i_ovf = 0; lb.i_chan = 0; lb.i_data = 0; lb.i_shift = 0;
        p_ev = 0; p_esop = 0; p_ech = 0; p_edata = 0;
        model_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst o_valid", int'(bus.o_valid), 0);
        chk("rst o_sop", int'(bus.o_sop), 0);
        chk("rst o_chan", int'(bus.o_chan), 0);
        chk("rst o_data", int'(bus.o_data), 0);
        chk("rst legacy o_valid", int'(lb.o_valid), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // legacy half-weight match, also checks the 2-cycle latency exactly
        for (int i = 0; i < 5; i++) begin
            lb.i_valid = lv[i]; lb.i_sop = (i == 0); lb.i_chan = 0; lb.i_data = DATA_W'(ld[i]); lb.i_shift = 1;
            @(posedge clk);
            @(negedge clk);
            chk("legacy o_valid", int'(lb.o_valid), int'(lev[i]));
            if (lev[i]) begin
                chk("legacy o_sop", int'(lb.o_sop), int'(lsp[i]));
                chk("legacy o_data", int'(lb.o_data), led[i]);
            end
        end

        // weight k=2, mid-packet shift change ignored
        tbl.push_back(mk(1, 1, 0, 0, 100, 2, 1, 1, 0, 100));
        tbl.push_back(mk(1, 0, 0, 0, 200, 5, 1, 0, 0, 125));
`ifdef DSP_AVG_ROUND_EN
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 94));
`else
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 93));
`endif
        tbl.push_back(mk(0, 0, 0, 0, 4000, 0, 0, 0, 0, 0));
        // overflow on ch2 at index 3, then a clean packet, then a sop+ovf packet
        tbl.push_back(mk(1, 1, 0, 2, 100, 1, 1, 1, 2, 100));
        tbl.push_back(mk(1, 0, 0, 2, 300, 1, 1, 0, 2, 200));
        tbl.push_back(mk(1, 0, 0, 2, 500, 1, 1, 0, 2, 350));
        tbl.push_back(mk(1, 0, 1, 2, 700, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 2, 900, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 2, 1100, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 2, 1000, 1, 1, 1, 2, 1000));
        tbl.push_back(mk(1, 1, 1, 2, 2000, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 2, 2000, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 2, 3000, 1, 0, 0, 0, 0));
        // orphan samples on idle ch3
        tbl.push_back(mk(1, 0, 0, 3, 500, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 3, 600, 0, 0, 0, 0, 0));
        // interleaved back-to-back, k=1
        tbl.push_back(mk(1, 1, 0, 0, 1000, 1, 1, 1, 0, 1000));
        tbl.push_back(mk(1, 1, 0, 1, 40, 1, 1, 1, 1, 40));
        tbl.push_back(mk(1, 0, 0, 0, 2000, 1, 1, 0, 0, 1500));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 750));
        tbl.push_back(mk(1, 0, 0, 1, 80, 1, 1, 0, 1, 60));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        foreach (tbl[i]) step(tbl[i], 1'b0);

        // randomized traffic with gaps, sop/ovf and shift changes
        for (int i = 0; i < 400; i++) begin
            t = mk($urandom_range(0, 99) < 70, $urandom_range(0, 7) == 0, $urandom_range(0, 19) == 0,
                   $urandom_range(0, CHANNELS - 1), $urandom_range(0, (1 << DATA_W) - 1),
                   $urandom_range(0, (1 << SHIFT_W) - 1), 0, 0, 0, 0);
            step(t, 1'b1);
        end
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1);

        // reset in the middle of a ch1 packet
        step(mk(1, 1, 0, 1, 500, 1, 0, 0, 0, 0), 1'b1);
        step(mk(1, 0, 0, 1, 600, 1, 0, 0, 0, 0), 1'b1);
        bus.i_valid = 0;
        rst = 1'b1;
        #1;
        chk("async rst o_valid", int'(bus.o_valid), 0);
        chk("async rst o_sop", int'(bus.o_sop), 0);
        chk("async rst o_chan", int'(bus.o_chan), 0);
        chk("async rst o_data", int'(bus.o_data), 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        p_ev = 0;
        step(mk(1, 0, 0, 1, 700, 1, 0, 0, 0, 0), 1'b1);
        step(mk(1, 0, 0, 1, 800, 1, 0, 0, 0, 0), 1'b1);
        step(mk(1, 1, 0, 1, 300, 1, 0, 0, 0, 0), 1'b1);
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1);
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dsp_ema_averager.md
Name: dsp_ema_averager

Overview:
Multi-channel exponential moving averager for framed sample packets. It is the parametrised successor of the single-channel half-weight averager, with configurable sample width, channel count, fractional precision and per-packet weight 2^-k. It sits after the ADC framing logic. It tracks packet state per channel and suppresses output after an overflow-flagged sample until the next start of packet.

Parameters:
DATA_W, 12, sample and output width in bits
CHANNELS, 4, number of independent channels (>=1); CH_W = max(1, clog2(CHANNELS))
FRAC_W, 4, fractional guard bits held in each accumulator
SHIFT_W, 3, width of the weight-exponent input; k ranges 0..2^SHIFT_W-1

Ports:
i_clk  in  1  clock; all logic rising-edge
i_rst  in  1  asynchronous reset, active high
i_valid  in  1  input sample qualifier
i_sop  in  1  first sample of packet for i_chan
i_ovf  in  1  sample overflowed; drop this and the rest of the packet
i_chan  in  CH_W  channel tag
i_data  in  DATA_W  unsigned sample
i_shift  in  SHIFT_W  weight exponent k; sampled only on a valid sop
o_valid  out  1  output qualifier
o_sop  out  1  output is the first of its packet
o_chan  out  CH_W  channel tag of output
o_data  out  DATA_W  averaged value

Behaviour:
- Reset (async, i_rst=1):
  - All channels go to IDLE; accumulators and latched k are cleared to 0.
  - Pipeline valid bits are cleared; o_valid, o_sop, o_chan and o_data are all 0.
  - Reset mid-packet discards everything in flight.
- Per-channel state: acc[DATA_W+FRAC_W-1:0], k[SHIFT_W-1:0], st in {IDLE, RUN, DROP}.
- Transitions on an i_valid sample for channel c:
  - sop & !ovf -> RUN. acc = i_data<<FRAC_W; k = i_shift; emit output with o_sop=1.
  - sop & ovf -> DROP. No output; acc unchanged.
  - !sop & st==RUN & !ovf -> stays RUN; acc updated; emit output.
  - !sop & st==RUN & ovf -> DROP. No output for this or any later sample until the next sop.
  - !sop & st in {IDLE, DROP} -> no output, no state change.
- Update rule: d = (x<<FRAC_W) - acc, signed, DATA_W+FRAC_W+1 bits; acc_new = acc + (d >>> k), arithmetic shift (floor).
  - Result always stays within the unsigned accumulator range.
  - k=0 gives passthrough.
  - With k=1 and FRAC_W=0 the result is bit-exact to the legacy rule floor((acc+x)/2).
- Output value: o_data = acc_new >> FRAC_W (truncate), unless DSP_AVG_ROUND_EN is defined.
- Latency: exactly 2 cycles from i_valid to o_valid.
  - Stage 1 registers the inputs.
  - Stage 2 computes, writes channel state and registers the outputs.
- Throughput and hazards:
  - One sample per cycle, any channel order; no backpressure.
  - Back-to-back samples on the same channel must use the just-updated acc, st and k (forwarding or write-before-read); no bubbles allowed.
- i_valid=0 cycles leave all state untouched. Gaps inside a packet are legal.
- i_shift changes mid-packet have no effect until that channel's next sop.
- o_chan, o_sop and o_data hold their last values while o_valid=0.

Optional Feature:
DSP_AVG_ROUND_EN
- Defined: o_data = (acc_new + 2^(FRAC_W-1)) >> FRAC_W, round half up, saturated to 2^DATA_W-1. FRAC_W=0 disables rounding.
- Undefined: truncation as above. Accumulator behaviour is identical in both builds.

Test Plan:
- Legacy match (CHANNELS=1, FRAC_W=0, k=1): ch0 sop 100, then 200, 50 -> o_data 100, 150, 100 with o_sop 1,0,0; o_valid exactly 2 cycles after each input.
- Weight k=2, FRAC_W=4: sop 100, then 200, 0 -> 100, 125, 93; with DSP_AVG_ROUND_EN -> 100, 125, 94.
- Overflow: 6-sample packet on ch2, k=1, i_ovf on index 3 -> only 3 outputs. A following sop packet outputs normally. sop+ovf together -> no outputs for that packet.
- Interleave, back-to-back, k=1: ch0 sop 1000, ch1 sop 40, ch0 2000, ch0 0, ch1 80 -> (ch0,1000), (ch1,40), (ch0,1500), (ch0,750), (ch1,60).
- Orphan and gaps: non-sop samples on IDLE ch3 -> no output. A packet with random i_valid gaps matches the reference model; i_shift changed mid-packet is ignored.
- Reset mid-packet: assert i_rst between samples 2 and 3 of a ch1 packet -> outputs 0 immediately (async), pending output dropped. Post-reset non-sop ch1 samples give no output until a new sop.
